// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: opcode and state
// encodings plus divider iteration count.
package muldiv_pkg;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 5;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MUL   = 3'd6
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } md_state_t;

   function automatic logic is_mul_op(input md_op_t op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative unsigned restoring divider datapath: one shift-subtract step per
// enabled cycle; the sequencer owns iteration count and sign handling.
module muldiv_div_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            early,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] rem, quo, dvs;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            fits;

   // rem < dvs keeps the true difference below 2^XLEN, so a modular
   // subtract of the low bits is exact whenever the trial fits.
   assign shifted = {rem, quo[XLEN-1]};
   assign fits    = (shifted >= {1'b0, dvs});
   assign diff    = shifted[XLEN-1:0] - dvs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
      end else if (load) begin
         dvs <= divisor;
         if (early) begin
            rem <= dividend;
            quo <= '0;
         end else begin
            rem <= '0;
            quo <= dividend;
         end
      end else if (step) begin
         rem <= fits ? diff : shifted[XLEN-1:0];
         quo <= {quo[XLEN-2:0], fits};
      end
   end

   assign quotient  = quo;
   assign remainder = rem;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide execution controller beside the EX-stage ALU.
// Optional MULDIV_EARLY_OUT_EN: divides with |a| < |b| skip straight to FIX.
//
// state | meaning
// IDLE  | op_ready high; MTHI/MTLO complete here, other ops start
// MUL   | product registered, waiting out MUL_STAGES retiming cycles
// DIV   | one restoring divide iteration per cycle (DIV_ITERS cycles)
// FIX   | apply quotient/remainder signs, write HI/LO, pulse done
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            op_valid,
   input  md_op_t          op_code,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            op_ready,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic [XLEN-1:0] result,
   output logic            done
);

   md_state_t         state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   md_op_t            op_q;
   logic [2*XLEN-1:0] prod, prod_q;
   logic              sa_q, neg_q, bz_q;
   logic              accept, mul_fin, div_fin, div_load, div_early, div_step;
   logic              div_signed, mul_signed;
   logic [XLEN-1:0]   abs_a, abs_b, quo, rem;

   assign accept     = op_valid & (state == ST_IDLE) & ~flush;
   assign div_signed = (op_code == OP_DIV);
   assign mul_signed = (op_code == OP_MULT);
   assign abs_a      = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
   assign abs_b      = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;

   // Extending to 2*XLEN makes one truncated multiply serve signed and unsigned.
   assign prod = {{XLEN{mul_signed & op_a[XLEN-1]}}, op_a} *
                 {{XLEN{mul_signed & op_b[XLEN-1]}}, op_b};

   assign op_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      mul_fin   = 1'b0;
      div_fin   = 1'b0;
      div_load  = 1'b0;
      div_early = 1'b0;
      div_step  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul_op(op_code)) begin
                  state_n = ST_MUL;
                  cnt_n   = CNT_W'(MUL_STAGES - 1);
               end else if (op_code == OP_DIV || op_code == OP_DIVU) begin
                  div_load = 1'b1;
                  state_n  = ST_DIV;
                  cnt_n    = CNT_W'(DIV_ITERS - 1);
`ifdef MULDIV_EARLY_OUT_EN
                  if (abs_b != '0 && abs_a < abs_b) begin
                     div_early = 1'b1;
                     state_n   = ST_FIX;
                     cnt_n     = '0;
                  end
`endif
               end
            end
         end
         ST_MUL: begin
            if (cnt == '0) begin
               state_n = ST_IDLE;
               mul_fin = 1'b1;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_DIV: begin
            div_step = 1'b1;
            if (cnt == '0) state_n = ST_FIX;
            else           cnt_n   = cnt - 1'b1;
         end
         ST_FIX: begin
            state_n = ST_IDLE;
            div_fin = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
      // A kill wins everywhere, including the completing cycle.
      if (flush) begin
         state_n  = ST_IDLE;
         cnt_n    = '0;
         mul_fin  = 1'b0;
         div_fin  = 1'b0;
         div_step = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_q   <= OP_MULT;
         prod_q <= '0;
         sa_q   <= 1'b0;
         neg_q  <= 1'b0;
         bz_q   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         done  <= mul_fin | div_fin;
         if (accept) begin
            op_q <= op_code;
            case (op_code)
               OP_MTHI: hi <= op_a;
               OP_MTLO: lo <= op_a;
               OP_MULT, OP_MULTU, OP_MUL: prod_q <= prod;
               OP_DIV, OP_DIVU: begin
                  sa_q  <= div_signed & op_a[XLEN-1];
                  neg_q <= div_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
                  bz_q  <= (op_b == '0);
               end
               default: ;
            endcase
         end
         if (mul_fin) begin
            if (op_q == OP_MUL) result   <= prod_q[XLEN-1:0];
            else                {hi, lo} <= prod_q;
         end
         if (div_fin) begin
            lo <= bz_q ? '1 : (neg_q ? -quo : quo);
            hi <= sa_q ? -rem : rem;
         end
      end
   end

   muldiv_div_core #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .early     (div_early),
      .step      (div_step),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (quo),
      .remainder (rem)
   );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int XLEN = 32;
   localparam int MS   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   md_op_t      op_code = OP_MULT;
   logic [31:0] op_a = '0, op_b = '0;
   logic        flush = 1'b0;
   logic        op_ready, busy, done;
   logic [31:0] hi, lo, result;

   int n_chk = 0;
   int n_pass = 0;

   muldiv_sequencer #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_a(op_a), .op_b(op_b), .flush(flush), .op_ready(op_ready),
      .busy(busy), .hi(hi), .lo(lo), .result(result), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: an op either completes now (MTxx) or after a known
   // number of cycles, at which point precomputed arithmetic results commit.
   int          m_left = 0;
   logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;
   logic        m_done = 1'b0;
   logic [31:0] p_hi, p_lo, p_res;
   logic        p_res_only;

   always @(posedge clk or posedge reset) begin
      longint      sa, sb, ma, mb, q, r;
      logic [63:0] p64;
      logic        early;
      if (reset) begin
         m_left = 0; m_hi = '0; m_lo = '0; m_res = '0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            if (flush) m_left = 0;
            else begin
               m_left--;
               if (m_left == 0) begin
                  m_done = 1'b1;
                  if (p_res_only) m_res = p_res;
                  else begin m_hi = p_hi; m_lo = p_lo; end
               end
            end
         end else if (op_valid && !flush) begin
            sa = $signed(op_a);
            sb = $signed(op_b);
            case (op_code)
               OP_MTHI: m_hi = op_a;
               OP_MTLO: m_lo = op_a;
               OP_MULT, OP_MULTU: begin
                  if (op_code == OP_MULT) p64 = sa * sb;
                  else                    p64 = {32'h0, op_a} * {32'h0, op_b};
                  p_hi = p64[63:32]; p_lo = p64[31:0];
                  p_res_only = 1'b0; m_left = MS;
               end
               OP_MUL: begin
                  p_res = op_a * op_b; p_res_only = 1'b1; m_left = MS;
               end
               OP_DIV, OP_DIVU: begin
                  p_res_only = 1'b0;
                  if (op_code == OP_DIV) begin
                     ma = (sa < 0) ? -sa : sa;
                     mb = (sb < 0) ? -sb : sb;
                  end else begin
                     ma = longint'({32'h0, op_a});
                     mb = longint'({32'h0, op_b});
                  end
                  if (op_b == 0) begin
                     p_lo = 32'hFFFF_FFFF; p_hi = op_a;
                  end else if (op_code == OP_DIV) begin
                     q = sa / sb; r = sa % sb;
                     p_lo = q[31:0]; p_hi = r[31:0];
                  end else begin
                     p_lo = op_a / op_b; p_hi = op_a % op_b;
                  end
`ifdef MULDIV_EARLY_OUT_EN
                  early = (op_b != 0) && (ma < mb);
`else
                  early = 1'b0;
`endif
                  m_left = early ? 1 : 33;
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("busy",     64'(busy),     64'(m_left > 0));
         check("op_ready", 64'(op_ready), 64'(m_left == 0));
         check("done",     64'(done),     64'(m_done));
         check("hi",       64'(hi),       64'(m_hi));
         check("lo",       64'(lo),       64'(m_lo));
         check("result",   64'(result),   64'(m_res));
      end
   end

   task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output int dcnt);
      int i;
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = op; op_a = a; op_b = b;
      @(posedge clk); #1;
      op_valid = 1'b0;
      bcyc = 0; dcnt = 0; i = 0;
      while (busy && i < 200) begin
         bcyc++; i++;
         @(posedge clk); #1;
      end
      if (done) dcnt++;
      @(posedge clk); #1;
      if (done) dcnt++;
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         5: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   int bc, dc, exp_early;

   initial begin
`ifdef MULDIV_EARLY_OUT_EN
      exp_early = 1;
`else
      exp_early = 33;
`endif
      #12;
      check("rst_hi", 64'(hi), 64'h0);
      check("rst_lo", 64'(lo), 64'h0);
      check("rst_result", 64'(result), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_op_ready", 64'(op_ready), 64'h1);
      @(posedge clk); #1; reset = 1'b0;

      // MTHI then MTLO back-to-back
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = OP_MTHI; op_a = 32'h1234;
      @(posedge clk); #1;
      check("mthi_busy", 64'(busy), 64'h0);
      op_code = OP_MTLO; op_a = 32'h5678;
      @(posedge clk); #1;
      op_valid = 1'b0;
      check("mtlo_busy", 64'(busy), 64'h0);
      check("mtx_hi", 64'(hi), 64'h1234);
      check("mtx_lo", 64'(lo), 64'h5678);

      issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, bc, dc);
      check("mult_busy_cycles", 64'(bc), 64'(MS));
      check("mult_done_pulses", 64'(dc), 64'h1);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFFE);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, bc, dc);
      check("multu_hi", 64'(hi), 64'h1);
      check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
      issue(OP_MUL, 32'd7, 32'd6, bc, dc);
      check("mul_result", 64'(result), 64'd42);
      check("mul_hi_kept", 64'(hi), 64'h1);
      check("mul_lo_kept", 64'(lo), 64'hFFFF_FFFE);

      issue(OP_DIV, -32'sd7, 32'd2, bc, dc);
      check("div_busy_cycles", 64'(bc), 64'd33);
      check("div_done_pulses", 64'(dc), 64'h1);
      check("div_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_hi", 64'(hi), 64'hFFFF_FFFF);
      issue(OP_DIVU, 32'd100, 32'd0, bc, dc);
      check("divu0_busy_cycles", 64'(bc), 64'd33);
      check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
      check("divu0_hi", 64'(hi), 64'd100);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
      check("divovf_lo", 64'(lo), 64'h8000_0000);
      check("divovf_hi", 64'(hi), 64'h0);

      // flush at iteration 10 of DIVU 10/3
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = OP_DIVU; op_a = 32'd10; op_b = 32'd3;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("flush_busy_before", 64'(busy), 64'h1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy_after", 64'(busy), 64'h0);
      check("flush_done", 64'(done), 64'h0);
      check("flush_hi", 64'(hi), 64'h0);
      check("flush_lo", 64'(lo), 64'h8000_0000);
      @(posedge clk); #1;
      check("flush_done_late", 64'(done), 64'h0);

      // reset at iteration 5 of another DIV
      @(posedge clk); #1;
      op_valid = 1'b1; op_code = OP_DIV; op_a = 32'd1000; op_b = 32'd7;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3; reset = 1'b1; #1;
      check("midrst_busy", 64'(busy), 64'h0);
      check("midrst_ready", 64'(op_ready), 64'h1);
      check("midrst_hi", 64'(hi), 64'h0);
      check("midrst_lo", 64'(lo), 64'h0);
      check("midrst_result", 64'(result), 64'h0);
      check("midrst_done", 64'(done), 64'h0);
      @(posedge clk); #1; reset = 1'b0;

      issue(OP_DIVU, 32'd3, 32'd10, bc, dc);
      check("early_busy_cycles", 64'(bc), 64'(exp_early));
      check("early_lo", 64'(lo), 64'h0);
      check("early_hi", 64'(hi), 64'd3);

      // randomized traffic: ops while busy, flushes, edge operands
      repeat (6000) begin
         @(posedge clk); #1;
         op_valid = ($urandom_range(0, 3) == 0);
         op_code  = md_op_t'($urandom_range(0, 6));
         op_a     = rnd_operand();
         op_b     = rnd_operand();
         flush    = ($urandom_range(0, 60) == 0);
      end
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
